// File: rtl/fifo_tog_pkg.sv
// Shared sizing constants for the toggle-bit FIFO.
package fifo_tog_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/fifo_tog_mem.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module fifo_tog_mem
   import fifo_tog_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Array is intentionally not reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_tog.sv
// Single-clock FIFO with exported pointer wrap bits and misuse error pulses.
module fifo_tog
   import fifo_tog_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              r_en,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic              wr_tog,
   output logic              rd_tog,
   output logic              w_er,
   output logic              r_er
);

   // Pointer and wrap bit share one register so the wrap falls out of the carry.
   logic [ADDR_W:0]   wr_cnt, rd_cnt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_fire, rd_fire;

   assign wr_ptr = wr_cnt[ADDR_W-1:0];
   assign rd_ptr = rd_cnt[ADDR_W-1:0];
   assign wr_tog = wr_cnt[ADDR_W];
   assign rd_tog = rd_cnt[ADDR_W];

   assign empty = (wr_ptr == rd_ptr) && (wr_tog == rd_tog);
   assign full  = (wr_ptr == rd_ptr) && (wr_tog != rd_tog);

   assign wr_fire = w_en && !full;
   assign rd_fire = r_en && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         w_er   <= 1'b0;
         r_er   <= 1'b0;
      end else begin
         if (wr_fire) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
         if (rd_fire) rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
         w_er <= w_en && full;
         r_er <= r_en && empty;
      end
   end

   // A read only fires when non-empty, so it never targets the slot being written.
   fifo_tog_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_fire),
      .waddr (wr_ptr),
      .wdata (wdata),
      .re    (rd_fire),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_fifo_tog.sv
// Directed bench for fifo_tog: reset, fill/drain, wrap streaming, simultaneous ops, async reset.
module tb_fifo_tog;

   logic       clk = 1'b0;
   logic       rst;
   logic       w_en, r_en;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       full, empty, wr_tog, rd_tog, w_er, r_er;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [7:0] q[$];
   logic [7:0] exp_rd;
   int         wcnt, rcnt;

   always #5 clk = ~clk;

   fifo_tog dut (
      .clk    (clk),
      .rst    (rst),
      .w_en   (w_en),
      .wdata  (wdata),
      .r_en   (r_en),
      .rdata  (rdata),
      .full   (full),
      .empty  (empty),
      .wr_tog (wr_tog),
      .rd_tog (rd_tog),
      .w_er   (w_er),
      .r_er   (r_er)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0; wdata = 8'h00;

      // reset held three cycles
      repeat (3) tick();
      chk_val("rst_empty",  empty,  1);
      chk_val("rst_full",   full,   0);
      chk_val("rst_wr_tog", wr_tog, 0);
      chk_val("rst_rd_tog", rd_tog, 0);
      chk_val("rst_w_er",   w_er,   0);
      chk_val("rst_r_er",   r_er,   0);
      chk_val("rst_rdata",  rdata,  0);
      rst = 1'b1;
      tick();

      // fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         w_en = 1'b1; wdata = 8'(i);
         tick();
         if (i == 15) chk_val("fill15_full", full, 0);
      end
      chk_val("fill_full",   full,   1);
      chk_val("fill_empty",  empty,  0);
      chk_val("fill_wr_tog", wr_tog, 1);
      chk_val("fill_rd_tog", rd_tog, 0);

      // overflow write
      wdata = 8'hAA;
      tick();
      w_en = 1'b0;
      chk_val("ovf_w_er", w_er, 1);
      chk_val("ovf_full", full, 1);
      tick();
      chk_val("ovf_w_er_clr", w_er, 0);

      // drain
      for (int i = 1; i <= 16; i++) begin
         r_en = 1'b1;
         tick();
         chk_val($sformatf("drain_rdata%0d", i), rdata, 32'(i));
         chk_val("drain_r_er", r_er, 0);
      end
      chk_val("drain_empty",  empty,  1);
      chk_val("drain_rd_tog", rd_tog, 1);

      // underflow read
      tick();
      r_en = 1'b0;
      chk_val("unf_r_er",  r_er,  1);
      chk_val("unf_rdata", rdata, 8'h10);
      tick();
      chk_val("unf_r_er_clr", r_er, 0);

      // wrap streaming: preload 8 then 40 interleaved ops
      wcnt = 16; rcnt = 16;
      for (int k = 0; k < 8; k++) begin
         w_en = 1'b1; wdata = 8'h20 + 8'(k);
         q.push_back(wdata); wcnt++;
         tick();
      end
      for (int j = 0; j < 40; j++) begin
         w_en = 1'b1; r_en = 1'b1; wdata = 8'h28 + 8'(j);
         q.push_back(wdata); wcnt++;
         exp_rd = q.pop_front(); rcnt++;
         tick();
         chk_val("wrap_rdata",  rdata,  exp_rd);
         chk_val("wrap_err",    {w_er, r_er}, 0);
         chk_val("wrap_wr_tog", wr_tog, 32'((wcnt / 16) % 2));
         chk_val("wrap_rd_tog", rd_tog, 32'((rcnt / 16) % 2));
      end
      r_en = 1'b0;

      // top up to full, then simultaneous read+write
      for (int k = 0; k < 8; k++) begin
         w_en = 1'b1; wdata = 8'h80 + 8'(k);
         q.push_back(wdata);
         tick();
      end
      w_en = 1'b0;
      chk_val("sim_pre_full", full, 1);
      w_en = 1'b1; r_en = 1'b1; wdata = 8'hEE;
      exp_rd = q.pop_front();
      tick();
      w_en = 1'b0; r_en = 1'b0;
      chk_val("simf_rdata", rdata, exp_rd);
      chk_val("simf_w_er",  w_er,  1);
      chk_val("simf_r_er",  r_er,  0);
      chk_val("simf_full",  full,  0);

      // drain remaining 15; 0xEE must never appear
      for (int k = 0; k < 15; k++) begin
         r_en = 1'b1;
         exp_rd = q.pop_front();
         tick();
         chk_val("simf_drain", rdata, exp_rd);
      end
      r_en = 1'b0;
      chk_val("sime_pre_empty", empty, 1);

      // empty + both
      w_en = 1'b1; r_en = 1'b1; wdata = 8'h77;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      chk_val("sime_r_er",  r_er,  1);
      chk_val("sime_w_er",  w_er,  0);
      chk_val("sime_empty", empty, 0);
      chk_val("sime_rdata", rdata, exp_rd);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk_val("sime_rd77",   rdata, 8'h77);
      chk_val("sime_empty2", empty, 1);

      // mid-operation async reset
      for (int k = 0; k < 5; k++) begin
         w_en = 1'b1; wdata = 8'h61 + 8'(k);
         tick();
      end
      w_en = 1'b0;
      chk_val("mrst_pre_empty", empty, 0);
      #2 rst = 1'b0;
      #1;
      chk_val("mrst_empty",  empty,  1);
      chk_val("mrst_full",   full,   0);
      chk_val("mrst_wr_tog", wr_tog, 0);
      chk_val("mrst_rd_tog", rd_tog, 0);
      chk_val("mrst_rdata",  rdata,  0);
      tick();
      rst = 1'b1;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk_val("mrst_r_er",  r_er,  1);
      chk_val("mrst_rdata2", rdata, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_tog.md
Name: fifo_tog

Overview:
- Single-clock synchronous FIFO with registered read data and full/empty status.
- Exports pointer wrap-toggle bits (wr_tog, rd_tog) and one-cycle overflow/underflow error pulses (w_er, r_er).
- Sits between a producer and a consumer in the same clock domain, as a drop-in buffer with self-reporting misuse.

Parameters:
- DATA_W, 8, width of wdata/rdata.
- ADDR_W, 4, address bits; depth = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  single clock for write and read sides; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately on falling edge, released synchronously by design of the driver).
- w_en  input  1  write request.
- wdata  input  DATA_W  write data, sampled with w_en.
- r_en  input  1  read request.
- rdata  output  DATA_W  read data, registered.
- full  output  1  FIFO holds 2**ADDR_W entries.
- empty  output  1  FIFO holds 0 entries.
- wr_tog  output  1  write-pointer wrap bit.
- rd_tog  output  1  read-pointer wrap bit.
- w_er  output  1  write-overflow error pulse.
- r_er  output  1  read-underflow error pulse.

Behaviour:
- State: wr_ptr[ADDR_W-1:0], wr_tog, rd_ptr[ADDR_W-1:0], rd_tog, memory of 2**ADDR_W x DATA_W.
- Reset (rst=0): wr_ptr=rd_ptr=0, wr_tog=rd_tog=0, rdata=0, w_er=r_er=0; hence empty=1, full=0. Memory contents are not reset.
- Flag decode is combinational from registered pointers:
  - empty = (wr_ptr==rd_ptr) && (wr_tog==rd_tog).
  - full = (wr_ptr==rd_ptr) && (wr_tog!=rd_tog).
  - Flags reflect an operation on the edge after it.
- Write accept:
  - Condition: w_en && !full (full as seen before the edge).
  - Action: mem[wr_ptr] <= wdata; wr_ptr increments modulo 2**ADDR_W.
  - Wrap: when wr_ptr wraps from 2**ADDR_W-1 to 0, wr_tog inverts.
- Read accept:
  - Condition: r_en && !empty.
  - Action: rdata <= mem[rd_ptr]; rd_ptr increments; rd_tog inverts on wrap.
  - Latency: data valid on rdata one clock after the accepting edge.
  - rdata holds its last value when no read is accepted.
- w_er is registered:
  - Set to 1 for exactly the cycle following an edge where w_en && full.
  - Otherwise 0.
  - The write is dropped: no pointer or memory change.
- r_er is registered:
  - Set to 1 for the cycle following an edge where r_en && empty.
  - Otherwise 0.
  - The read is dropped: rdata unchanged.
- Simultaneous w_en && r_en:
  - Each side is evaluated independently against pre-edge flags.
  - Neither full nor empty: both accepted; occupancy unchanged.
  - When full: read accepted, write rejected with w_er.
  - When empty: write accepted, read rejected with r_er.
  - Read never bypasses a same-cycle write.
- Reset mid-operation: all pointers, toggles, flags, errors and rdata return to reset values immediately; buffered data is discarded.
- Occupancy invariant: count = {wr_tog,wr_ptr} - {rd_tog,rd_ptr}, computed in ADDR_W+1 bits, always within 0..2**ADDR_W.

Decomposition:
- Shared package fifo_tog_pkg holds the default DATA_W/ADDR_W constants and a DEPTH = 2**ADDR_W localparam.
- One sub-module is natural: fifo_tog_mem, a simple dual-port RAM.
  - Synchronous write port.
  - Synchronous registered read port with read enable.
  - Pointer/flag/error logic stays in fifo_tog.

Test Plan:
- Reset: hold rst=0 three cycles -> empty=1, full=0, wr_tog=rd_tog=0, w_er=r_er=0, rdata=0.
- Fill/overflow:
  - Write 0x01..0x10 (16 writes) -> full=1 after 16th edge, wr_tog=1, wr_ptr=0.
  - 17th write of 0xAA -> w_er=1 for one cycle; contents unchanged.
- Drain/underflow:
  - Read 16 times -> rdata sequence 0x01..0x10, each one cycle after its read edge; empty=1, rd_tog=1.
  - 17th read -> r_er=1 one cycle; rdata stays 0x10.
- Wrap: with 8 entries queued, stream 40 writes/reads interleaved -> data order preserved; toggles invert every 16 operations of each side; no error pulses.
- Simultaneous:
  - Full + w_en&r_en -> oldest word read, write dropped, w_er=1, full deasserts.
  - Empty + both -> write stored, r_er=1, empty deasserts.
- Mid-operation reset: after 5 writes assert rst=0 asynchronously between edges -> empty=1 immediately; next read gives r_er=1.
